// File: rtl/grid_row_scanner.sv
// Row-scanning LED matrix driver for the 8x8 Life core, with a shadow frame and one-deep pending buffer.
// Optional macro SCAN_BLANK_EN inserts one dark BLANK cycle after every row's dwell.
module grid_row_scanner #(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

    state_t         state_q, state_d;
    logic [2:0]     row_q, row_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [63:0]    shadow_q, shadow_d;
    logic [63:0]    pending_q, pending_d;
    logic           pend_flag_q, pend_flag_d;
    logic           dwell_end;
    logic           boundary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            dwell_q     <= '0;
            shadow_q    <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
        end
    end

    assign dwell_end = (dwell_q == DWELL_LAST);

    // The boundary is the edge that closes a frame; frame_done marks the cycle before it.
`ifdef SCAN_BLANK_EN
    assign boundary = (state_q == BLANK) && (row_q == 3'd7);
`else
    assign boundary = (state_q == SCAN) && (row_q == 3'd7) && dwell_end;
`endif

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        dwell_d     = dwell_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;

        case (state_q)
            IDLE: begin
                if (grid_valid) begin
                    shadow_d = grid_in;
                    row_d    = 3'd0;
                    dwell_d  = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (dwell_end) begin
                    dwell_d = '0;
`ifdef SCAN_BLANK_EN
                    state_d = BLANK;
`else
                    row_d   = row_q + 3'd1;
`endif
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                row_d   = row_q + 3'd1;
                state_d = SCAN;
            end
`endif
            default: state_d = IDLE;
        endcase

        // A word arriving exactly on the boundary goes straight to the display and supersedes any pending one.
        if (state_q != IDLE) begin
            if (boundary) begin
                if (grid_valid) begin
                    shadow_d = grid_in;
                end else if (pend_flag_q) begin
                    shadow_d = pending_q;
                end
                pend_flag_d = 1'b0;
            end else if (grid_valid) begin
                pending_d   = grid_in;
                pend_flag_d = 1'b1;
            end
        end
    end

    always_comb begin
        row_sel    = 8'd0;
        col_data   = 8'd0;
        frame_done = boundary;
        if (state_q == SCAN) begin
            row_sel  = 8'd1 << row_q;
            col_data = shadow_q[{~row_q, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_grid_row_scanner.sv
// Scoreboard bench for grid_row_scanner: stimulus queues expected lit cycles, a negedge monitor checks them.
module tb_grid_row_scanner;

    localparam int DWELL = 4;
`ifdef SCAN_BLANK_EN
    localparam int BL = 1;
`else
    localparam int BL = 0;
`endif
    localparam int P = DWELL + BL;
    localparam int F = 8 * P;

    localparam logic [63:0] SEED = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] XPAT = 64'h8000_0000_0000_0001;
    localparam logic [63:0] YPAT = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ZPAT = 64'h5555_AAAA_5555_AAAA;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] grid_in = '0;
    logic        grid_valid = 1'b0;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    typedef struct {
        int         cyc;
        logic [7:0] rs;
        logic [7:0] cd;
        logic       fd;
    } exp_t;
    exp_t q[$];

    grid_row_scanner #(.DWELL(DWELL)) dut (
        .clk        (clk),
        .reset      (reset),
        .grid_in    (grid_in),
        .grid_valid (grid_valid),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every cycle with a lit row or frame_done must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && (row_sel != 8'd0 || frame_done)) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output cyc=%0d got rs=%02h cd=%02h fd=%0b, required no output",
                         cycle, row_sel, col_data, frame_done);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cycle || e.rs != row_sel || e.cd != col_data || e.fd != frame_done) begin
                    fails++;
                    $display("FAIL scan_cycle got cyc=%0d rs=%02h cd=%02h fd=%0b, required cyc=%0d rs=%02h cd=%02h fd=%0b",
                             cycle, row_sel, col_data, frame_done, e.cyc, e.rs, e.cd, e.fd);
                end else begin
                    $display("[TB] cyc=%0d rs=%02h cd=%02h fd=%0b ok", cycle, row_sel, col_data, frame_done);
                end
            end
        end
    end

    task automatic push_frame(input int base, input logic [63:0] cols, input int limit);
        for (int r = 0; r < 8; r++) begin
            for (int d = 0; d < DWELL; d++) begin
                exp_t e;
                e.cyc = base + r * P + d;
                e.rs  = 8'd1 << r;
                e.cd  = cols[63 - 8 * r -: 8];
                e.fd  = (BL == 0) && (r == 7) && (d == DWELL - 1);
                if (e.cyc <= limit) q.push_back(e);
            end
        end
        if (BL != 0) begin
            exp_t e;
            e.cyc = base + 7 * P + DWELL;
            e.rs  = 8'd0;
            e.cd  = 8'd0;
            e.fd  = 1'b1;
            if (e.cyc <= limit) q.push_back(e);
        end
    endtask

    // Called at a negedge; drives a one-cycle grid_valid sampled by the edge that ends cycle t.
    task automatic pulse(input int t, input logic [63:0] data);
        tests++;
        if (cycle > t) begin
            fails++;
            $display("FAIL pulse_schedule got cyc=%0d, required <=%0d", cycle, t);
        end
        while (cycle < t) @(negedge clk);
        grid_valid = 1'b1;
        grid_in    = data;
        @(negedge clk);
        grid_valid = 1'b0;
        grid_in    = '0;
    endtask

    task automatic check_idle(input string name);
        tests++;
        if (row_sel != 8'd0 || col_data != 8'd0 || frame_done != 1'b0) begin
            fails++;
            $display("FAIL %s got rs=%02h cd=%02h fd=%0b, required all 0", name, row_sel, col_data, frame_done);
        end
    endtask

    task automatic check_queue_empty(input string name);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s got %0d expected entries left, required 0", name, q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base0, base1, base2, base3, cr;

        repeat (10) @(negedge clk);
        check_idle("reset_outputs");
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_idle("idle_no_valid");
        end

        // First load of S, then new words mid-frame land one frame later.
        base0 = cycle + 1;
        base1 = base0 + F;
        base2 = base1 + F;
        base3 = base2 + F;
        push_frame(base0, SEED, 1 << 30);
        push_frame(base1, SEED, 1 << 30);
        pulse(cycle, SEED);
        pulse(base1 + 2 * P + 1, ONES);
        pulse(base1 + 5 * P + 1, XPAT);
        push_frame(base2, 64'h8000_0000_0000_0001, 1 << 30);

        // A pending word is overridden by a word arriving on the frame boundary.
        pulse(base2 + 3 * P + 1, YPAT);
        cr = base3 + 3 * P + 1;
        push_frame(base3, ONES, cr);
        pulse(base2 + F - 1, ONES);

        // Asynchronous reset mid row 3 with a pending word outstanding.
        pulse(base3 + P + 1, ZPAT);
        while (cycle < cr) @(negedge clk);
        #1 reset = 1'b1;
        #1 check_idle("async_reset_outputs");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_queue_empty("queue_after_reset");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle("idle_after_reset");
        end

        // Reload S after reset: row 0 follows immediately.
        base0 = cycle + 1;
        push_frame(base0, SEED, 1 << 30);
        pulse(cycle, SEED);
        while (cycle < base0 + F - 1) @(negedge clk);
        #2 check_queue_empty("queue_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
